// File: rtl/pll_rst_seq.sv
// PLL bring-up and staggered domain reset-release sequencer on the reference clock.
// Optional macro PLL_RST_SEQ_LOCK_RECOVER_EN: lock loss after release re-runs the PLL attempt instead of failing.
module pll_rst_seq #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 1024,
    parameter int LOCK_STABLE    = 32,
    parameter int STAGE_GAP      = 8,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       ref_clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       sw_rst_req,
    output logic       pll_rst,
    output logic [4:0] dom_rst,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_cnt
);

    localparam int CMAX_A = (PLL_RST_CYCLES > STAGE_GAP) ? PLL_RST_CYCLES : STAGE_GAP;
    localparam int CMAX   = (LOCK_TIMEOUT > CMAX_A) ? LOCK_TIMEOUT : CMAX_A;
    localparam int CW     = $clog2(CMAX + 1);
    localparam int SW     = $clog2(LOCK_STABLE + 1);

    localparam logic [CW-1:0] PRST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_END   = CW'(LOCK_TIMEOUT);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [SW-1:0] STAB_END  = SW'(LOCK_STABLE);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

`ifdef PLL_RST_SEQ_LOCK_RECOVER_EN
    localparam state_t LOSS_STATE = S_PLL_RST;
`else
    localparam state_t LOSS_STATE = S_FAIL;
`endif

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [SW-1:0] stab_reg, stab_next;
    logic [2:0]    stage_reg, stage_next;
    logic [1:0]    retry_reg, retry_next;
    logic [1:0]    sync_reg;
    logic          pll_rst_reg, ready_reg, fail_reg;
    logic [4:0]    dom_rst_reg, dom_rst_next;
    logic          lock_s;

    assign lock_s = sync_reg[1];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stab_next  = stab_reg;
        stage_next = stage_reg;
        retry_next = retry_reg;
        if (sw_rst_req) begin
            state_next = S_PLL_RST;
            cnt_next   = '0;
            stab_next  = '0;
            stage_next = '0;
            retry_next = '0;
        end else begin
            case (state_reg)
                S_PLL_RST: begin
                    if (cnt_reg == PRST_LAST) begin
                        state_next = S_WAIT_LOCK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    cnt_next  = cnt_reg + CW'(1);
                    stab_next = lock_s ? stab_reg + SW'(1) : '0;
                    // A stable lock wins over a timeout landing on the same edge
                    if (lock_s && (stab_reg + SW'(1) == STAB_END)) begin
                        state_next = S_RELEASE;
                        cnt_next   = '0;
                        stab_next  = '0;
                        stage_next = '0;
                    end else if (cnt_reg + CW'(1) == TMO_END) begin
                        cnt_next  = '0;
                        stab_next = '0;
                        if (retry_reg < RETRY_MAX) begin
                            retry_next = retry_reg + 2'd1;
                            state_next = S_PLL_RST;
                        end else begin
                            state_next = S_FAIL;
                        end
                    end
                end
                S_RELEASE, S_RUN: begin
                    if (!lock_s) begin
                        state_next = LOSS_STATE;
                        cnt_next   = '0;
                        stab_next  = '0;
                        stage_next = '0;
                    end else if (state_reg == S_RELEASE) begin
                        if (stage_reg == 3'd5) begin
                            state_next = S_RUN;
                        end else if (cnt_reg == GAP_LAST) begin
                            cnt_next   = '0;
                            stage_next = stage_reg + 3'd1;
                        end else begin
                            cnt_next = cnt_reg + CW'(1);
                        end
                    end
                end
                S_FAIL: begin
                end
                default: begin
                    state_next = S_PLL_RST;
                end
            endcase
        end
    end

    // Domain gi is held in reset until gi+1 stages of the release have elapsed
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_dom
            assign dom_rst_next[gi] = (state_next == S_RUN)     ? 1'b0 :
                                      (state_next == S_RELEASE) ? (stage_next <= 3'(gi)) :
                                                                  1'b1;
        end
    endgenerate

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_PLL_RST;
            cnt_reg     <= '0;
            stab_reg    <= '0;
            stage_reg   <= '0;
            retry_reg   <= '0;
            sync_reg    <= '0;
            pll_rst_reg <= 1'b1;
            dom_rst_reg <= 5'h1F;
            ready_reg   <= 1'b0;
            fail_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            stab_reg    <= stab_next;
            stage_reg   <= stage_next;
            retry_reg   <= retry_next;
            sync_reg    <= {sync_reg[0], pll_locked};
            pll_rst_reg <= (state_next == S_PLL_RST) || (state_next == S_FAIL);
            dom_rst_reg <= dom_rst_next;
            ready_reg   <= (state_next == S_RUN);
            fail_reg    <= (state_next == S_FAIL);
        end
    end

    assign pll_rst   = pll_rst_reg;
    assign dom_rst   = dom_rst_reg;
    assign ready     = ready_reg;
    assign fail      = fail_reg;
    assign retry_cnt = retry_reg;

endmodule

// File: doc/pll_rst_seq.md
# pll_rst_seq

PLL bring-up and reset-release sequencer. It runs on the free-running reference clock and drives the generator PLL's reset. It qualifies lock with a stability window and a timeout, retries on failure, then releases the per-domain resets (rom, mem_a, mem_b, mem_c, ctrl) in a fixed staggered order. It replaces the direct `lock`/`rst` combination in the power controller, so no domain leaves reset on a glitchy or missing lock.

## Interface
Parameters:
- PLL_RST_CYCLES, 16: cycles pll_rst is held high per attempt (≥2)
- LOCK_TIMEOUT, 1024: cycles allowed in WAIT_LOCK before an attempt fails
- LOCK_STABLE, 32: consecutive synced-lock-high cycles required (< LOCK_TIMEOUT)
- STAGE_GAP, 8: cycles between successive domain reset releases (≥1)
- MAX_RETRIES, 3: timed-out attempts retried before FAIL (≤3)

Ports:
- ref_clk  in  1  reference clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pll_locked  in  1  PLL lock, asynchronous to ref_clk; 2-FF synchronised internally
- sw_rst_req  in  1  synchronous single-cycle request to re-run the full sequence
- pll_rst  out  1  PLL reset, active-high
- dom_rst  out  5  domain resets, active-high; [0] rom, [1] mem_a, [2] mem_b, [3] mem_c, [4] ctrl
- ready  out  1  all domains out of reset, lock stable
- fail  out  1  lock never achieved within the retry budget
- retry_cnt  out  2  timed-out attempts since last rst_n/sw_rst_req

## Operation
- Reset state (rst_n low): state=PLL_RST, counters 0, pll_rst=1, dom_rst=5'h1F, ready=0, fail=0, retry_cnt=0, sync FFs 0.
- PLL_RST: pll_rst=1, dom_rst=all 1. After PLL_RST_CYCLES cycles → WAIT_LOCK. pll_rst goes low on the transition.
- WAIT_LOCK: timeout counter increments every cycle. Stable counter increments on synced lock=1 and clears on synced lock=0.
  - Stable counter reaches LOCK_STABLE → RELEASE.
  - Timeout counter reaches LOCK_TIMEOUT first, with retry_cnt<MAX_RETRIES → retry_cnt+1, go to PLL_RST.
  - Timeout counter reaches LOCK_TIMEOUT first, with retry_cnt==MAX_RETRIES → FAIL.
  - If both counters expire in the same cycle, RELEASE wins.
- RELEASE: gap counter runs 0..STAGE_GAP-1. At each wrap, clear the next dom_rst bit in order [0]→[4]. The cycle after [4] clears → RUN.
- RUN: ready=1, dom_rst=0, pll_rst=0.
- FAIL: fail=1, pll_rst=1, dom_rst=all 1, ready=0. Leaves only on sw_rst_req or rst_n.
- Lock loss: synced lock=0 in RELEASE or RUN forces dom_rst=5'h1F and ready=0 on the next edge. Next state is per Configuration. retry_cnt does not change.
- sw_rst_req in any state → PLL_RST with counters cleared, retry_cnt=0, fail=0, dom_rst=all 1. It takes priority over all other transitions in that cycle.
- All outputs are registered.

## Timing
- pll_locked → internal view: 2 ref_clk cycles.
- After rst_n deasserts:
  - pll_rst is high for PLL_RST_CYCLES edges.
  - WAIT_LOCK is entered at edge PLL_RST_CYCLES.
- RELEASE is entered LOCK_STABLE edges after the first synced-high cycle of an unbroken run.
- dom_rst[i] falls (i+1)*STAGE_GAP edges after RELEASE entry.
- ready rises STAGE_GAP*5+1 edges after RELEASE entry.
- Lock loss to dom_rst all high: 3 edges from a pll_locked fall (2 sync + 1 registered).
- sw_rst_req to pll_rst=1 and dom_rst=all 1: 1 edge.
- Counter widths: $clog2(max parameter + 1); no wrap occurs within any state.

## Configuration
- PLL_RST_SEQ_LOCK_RECOVER_EN defined: lock loss in RELEASE/RUN → PLL_RST, a fresh attempt with retry_cnt unchanged.
- Macro undefined: lock loss in RELEASE/RUN → FAIL (fail=1). Recovery only via sw_rst_req or rst_n.

## Test plan
- Nominal: rst_n released, pll_locked=1 from cycle 20 → pll_rst low at cycle 16; dom_rst steps 1F→1E→1C→18→10→00 every 8 cycles; ready=1 at RELEASE+41.
- Glitchy lock: lock high 20 cycles, low 1 cycle, then steady → stable count restarts; RELEASE entered 32 cycles after the glitch recovers; no early dom_rst release.
- Never lock: pll_locked=0 → 4 PLL_RST pulses; retry_cnt 1,2,3; fail=1 after the 4th 1024-cycle timeout; dom_rst stays 1F.
- Lock loss in RUN: drop pll_locked → dom_rst=1F and ready=0 within 3 cycles.
  - With the macro: pll_rst pulses 16 cycles and the sequence reruns.
  - Without the macro: fail=1.
- sw_rst_req in FAIL and mid-RELEASE (dom_rst=1C) → next edge: pll_rst=1, dom_rst=1F, fail=0, retry_cnt=0; sequence restarts.
- rst_n asserted mid-RELEASE → all outputs take reset values immediately, without waiting for a ref_clk edge.
